// File: rtl/regex_imem_arbiter_pkg.sv
// Shared types and constants for the regex instruction-memory arbiter.
// The request struct is sized to the build's instruction address width.
package regex_imem_arbiter_pkg;

  localparam int IMEM_READ_LATENCY = 1;
  localparam int IMEM_ADDR_WIDTH   = 11;

  typedef struct packed {
    logic [IMEM_ADDR_WIDTH-1:0] addr;
    logic                       valid;
  } mem_req_t;

endpackage

// File: rtl/regex_imem_arbiter_if.sv
// Instruction-fetch bus between the regex CPUs and the shared instruction memory arbiter.
// Per-CPU valid/ready with packed per-CPU addresses; read data is broadcast to all CPUs.
interface regex_imem_arbiter_if #(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
);

  logic [N_CPU-1:0]                   cpu_memory_valid;
  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr;
  logic [N_CPU-1:0]                   cpu_memory_ready;
  logic [MEMORY_WIDTH-1:0]            cpu_memory_data;

  modport master (
    output cpu_memory_valid,
    output cpu_memory_addr,
    input  cpu_memory_ready,
    input  cpu_memory_data
  );

  modport slave (
    input  cpu_memory_valid,
    input  cpu_memory_addr,
    output cpu_memory_ready,
    output cpu_memory_data
  );

endinterface

// File: rtl/regex_imem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first unmasked requester after ptr, wrapping modulo N.
// Zero latency; an all-zero grant means nobody eligible this cycle.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = ptr;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      // N is a power of two, so truncating the sum is the modulo wrap.
      cand = IW'(int'(ptr) + i);
      if (!found && req[cand] && !mask[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regex_imem_arbiter.sv
// Shares one BRAM port between N_CPU instruction fetchers (round-robin) and a host loader.
// Grant one cycle after request, data one cycle after grant; host writes always preempt CPU reads.
module regex_imem_arbiter
  import regex_imem_arbiter_pkg::*;
#(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  regex_imem_arbiter_if.slave          cpu,
  input  logic                         host_wr_en,
  input  logic [MEMORY_ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [MEMORY_WIDTH-1:0]      host_wr_data,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [MEMORY_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEMORY_WIDTH-1:0]      mem_wdata,
  input  logic [MEMORY_WIDTH-1:0]      mem_rdata,
  output logic                         busy
);

  localparam int IW = (N_CPU > 1) ? $clog2(N_CPU) : 1;

  mem_req_t [N_CPU-1:0]         req;
  mem_req_t                     win;
  logic [N_CPU-1:0]             req_vld;
  logic [N_CPU-1:0]             ready_q;
  logic [N_CPU-1:0]             win_grant;
  logic [IW-1:0]                win_idx;
  logic [IW-1:0]                rr_ptr;
  logic [IMEM_READ_LATENCY-1:0] rd_pipe;
  logic                         rd_vld;

  always_comb begin
    req     = '0;
    req_vld = '0;
    for (int i = 0; i < N_CPU; i++) begin
      req[i].addr  = IMEM_ADDR_WIDTH'(cpu.cpu_memory_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH]);
      req[i].valid = cpu.cpu_memory_valid[i];
      req_vld[i]   = req[i].valid;
    end
  end

  // The CPU holding ready this cycle still shows valid; masking it stops a double grant.
  rr_arbiter #(.N(N_CPU)) u_rr (
    .req   (req_vld),
    .mask  (ready_q),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  always_comb begin
    win       = '0;
    win.addr  = req[win_idx].addr;
    win.valid = |win_grant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= IW'(N_CPU - 1);
      ready_q   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_pipe   <= '0;
    end else begin
      rd_pipe <= IMEM_READ_LATENCY'({rd_pipe, mem_en & ~mem_we});
      if (host_wr_en) begin
        // Displaced CPU requests stay pending and the pointer is untouched.
        ready_q   <= '0;
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= host_wr_addr;
        mem_wdata <= host_wr_data;
      end else if (win.valid) begin
        ready_q  <= win_grant;
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= MEMORY_ADDR_WIDTH'(win.addr);
        rr_ptr   <= win_idx;
      end else begin
        ready_q <= '0;
        mem_en  <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

  assign rd_vld               = rd_pipe[IMEM_READ_LATENCY-1];
  assign cpu.cpu_memory_ready = ready_q;
  assign cpu.cpu_memory_data  = rd_vld ? mem_rdata : '0;
  assign busy                 = rst & (|req_vld | |ready_q | rd_vld);

endmodule

// File: tb/tb_regex_imem_arbiter.sv
// Bench for regex_imem_arbiter: vector table, corner sequences and a random scoreboard run.
// Includes a behavioural single-port BRAM with one-cycle read latency.
module tb_regex_imem_arbiter;

  localparam int N  = 4;
  localparam int MW = 16;
  localparam int AW = 11;
  localparam logic [AW-1:0] A0 = 11'h100;
  localparam logic [AW-1:0] A1 = 11'h211;
  localparam logic [AW-1:0] A2 = 11'h05A;
  localparam logic [AW-1:0] A3 = 11'h7FF;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_wr_en;
  logic [AW-1:0] host_wr_addr;
  logic [MW-1:0] host_wr_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wdata, mem_rdata;
  logic          busy;
  logic [N-1:0]  v;
  logic [AW-1:0] a [N];

  always #5 clk = ~clk;

  regex_imem_arbiter_if #(.N_CPU(N), .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW)) bus ();
  assign bus.cpu_memory_valid = v;
  assign bus.cpu_memory_addr  = {a[3], a[2], a[1], a[0]};

  regex_imem_arbiter #(.N_CPU(N), .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (bus),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  function automatic logic [MW-1:0] pat(input int i);
    return MW'((i * 37) ^ 32'h0000A5C3);
  endfunction

  logic [MW-1:0] bram    [2**AW];
  logic [MW-1:0] ref_mem [2**AW];

  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 2**AW; i++) bram[i] = pat(i);
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) bram[mem_addr] = mem_wdata;
        else        mem_rdata <= bram[mem_addr];
      end
    end
  end

  int total = 0;
  int bad   = 0;
  logic [MW-1:0] exp_q [$];
  logic [N-1:0]  pend;
  int            age [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Read data is due the cycle after each grant pulse; grants queue the word the CPU asked for.
  task automatic score();
    logic [N-1:0] r;
    r = bus.cpu_memory_ready;
    if (exp_q.size() > 0) chk("rd_data", 32'(bus.cpu_memory_data), 32'(exp_q.pop_front()));
    chk("ready_onehot", 32'($countones(r) <= 1), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        chk("grant_addr", 32'(mem_addr), 32'(a[i]));
        exp_q.push_back(ref_mem[a[i]]);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    score();
  endtask

  task automatic handle_grants();
    for (int i = 0; i < N; i++) begin
      if (pend[i]) age[i]++;
      if (bus.cpu_memory_ready[i]) begin
        chk("grant_once", 32'(pend[i]), 32'd1);
        if (pend[i]) chk("grant_latency", 32'(age[i] <= N + 1), 32'd1);
        pend[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    v          = '0;
    host_wr_en = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic          h;
    logic [AW-1:0] haddr;
    logic [MW-1:0] hdata;
    logic [N-1:0]  r;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic          busy;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b1111, 1'b0, 11'h000, 16'h0000, 4'b0001, 1'b1, 1'b0, A0, 1'b1};
    tbl[1]  = '{4'b1111, 1'b0, 11'h000, 16'h0000, 4'b0010, 1'b1, 1'b0, A1, 1'b1};
    tbl[2]  = '{4'b1111, 1'b0, 11'h000, 16'h0000, 4'b0100, 1'b1, 1'b0, A2, 1'b1};
    tbl[3]  = '{4'b1111, 1'b0, 11'h000, 16'h0000, 4'b1000, 1'b1, 1'b0, A3, 1'b1};
    tbl[4]  = '{4'b1111, 1'b0, 11'h000, 16'h0000, 4'b0001, 1'b1, 1'b0, A0, 1'b1};
    tbl[5]  = '{4'b0001, 1'b0, 11'h000, 16'h0000, 4'b0000, 1'b0, 1'b0, 11'h000, 1'b1};
    tbl[6]  = '{4'b0000, 1'b0, 11'h000, 16'h0000, 4'b0000, 1'b0, 1'b0, 11'h000, 1'b0};
    tbl[7]  = '{4'b0100, 1'b0, 11'h000, 16'h0000, 4'b0100, 1'b1, 1'b0, A2, 1'b1};
    tbl[8]  = '{4'b0100, 1'b0, 11'h000, 16'h0000, 4'b0000, 1'b0, 1'b0, 11'h000, 1'b1};
    tbl[9]  = '{4'b0100, 1'b0, 11'h000, 16'h0000, 4'b0100, 1'b1, 1'b0, A2, 1'b1};
    tbl[10] = '{4'b0000, 1'b0, 11'h000, 16'h0000, 4'b0000, 1'b0, 1'b0, 11'h000, 1'b1};
    tbl[11] = '{4'b0010, 1'b1, 11'h333, 16'hBEEF, 4'b0000, 1'b1, 1'b1, 11'h333, 1'b1};
    tbl[12] = '{4'b0010, 1'b0, 11'h000, 16'h0000, 4'b0010, 1'b1, 1'b0, A1, 1'b1};
    tbl[13] = '{4'b0010, 1'b0, 11'h000, 16'h0000, 4'b0000, 1'b0, 1'b0, 11'h000, 1'b1};
    tbl[14] = '{4'b0000, 1'b0, 11'h000, 16'h0000, 4'b0000, 1'b0, 1'b0, 11'h000, 1'b0};

    for (int i = 0; i < 2**AW; i++) ref_mem[i] = pat(i);
    pend = '0;
    for (int i = 0; i < N; i++) age[i] = 0;
    a[0] = A0; a[1] = A1; a[2] = A2; a[3] = A3;
    v = '0; host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;

    // Reset: outputs quiet even with every CPU requesting.
    rst = 1'b1;
    #2 rst = 1'b0;
    v = 4'b1111;
    @(negedge clk);
    chk("rst_ready", 32'(bus.cpu_memory_ready), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    v = '0;
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 15; k++) begin
      v            = tbl[k].v;
      host_wr_en   = tbl[k].h;
      host_wr_addr = tbl[k].haddr;
      host_wr_data = tbl[k].hdata;
      if (tbl[k].h) ref_mem[tbl[k].haddr] = tbl[k].hdata;
      tick();
      chk("tbl_ready", 32'(bus.cpu_memory_ready), 32'(tbl[k].r));
      chk("tbl_mem_en", 32'(mem_en), 32'(tbl[k].en));
      if (tbl[k].en) begin
        chk("tbl_mem_we", 32'(mem_we), 32'(tbl[k].we));
        chk("tbl_mem_addr", 32'(mem_addr), 32'(tbl[k].addr));
      end
      if (tbl[k].en && tbl[k].we) chk("tbl_mem_wdata", 32'(mem_wdata), 32'(tbl[k].hdata));
      chk("tbl_busy", 32'(busy), 32'(tbl[k].busy));
    end

    // Host write beats CPU 1 reading the same word; CPU 1 then sees the new value.
    a[1] = 11'h010;
    v = 4'b0010;
    host_wr_en = 1'b1; host_wr_addr = 11'h010; host_wr_data = 16'h1234;
    ref_mem[11'h010] = 16'h1234;
    tick();
    chk("hw_ready", 32'(bus.cpu_memory_ready), 32'd0);
    chk("hw_mem_we", 32'(mem_we), 32'd1);
    chk("hw_mem_addr", 32'(mem_addr), 32'h010);
    chk("hw_mem_wdata", 32'(mem_wdata), 32'h1234);
    host_wr_en = 1'b0;
    tick();
    chk("hw_cpu1_grant", 32'(bus.cpu_memory_ready), 32'b0010);
    v = '0;
    tick();
    chk("hw_cpu1_data", 32'(bus.cpu_memory_data), 32'h1234);

    // Pointer wrap: CPU 3 wins, then CPU 0 is next.
    v = 4'b1000;
    tick();
    chk("wrap_cpu3", 32'(bus.cpu_memory_ready), 32'b1000);
    v = 4'b0001;
    tick();
    chk("wrap_cpu0", 32'(bus.cpu_memory_ready), 32'b0001);
    v = '0;
    tick();

    // Reset during a grant cycle.
    v = 4'b0010;
    @(posedge clk);
    #1;
    chk("rg_grant", 32'(bus.cpu_memory_ready), 32'b0010);
    rst = 1'b0;
    #1;
    chk("rg_ready", 32'(bus.cpu_memory_ready), 32'd0);
    chk("rg_mem_en", 32'(mem_en), 32'd0);
    chk("rg_mem_addr", 32'(mem_addr), 32'd0);
    chk("rg_busy", 32'(busy), 32'd0);
    chk("rg_data", 32'(bus.cpu_memory_data), 32'd0);
    v = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rg_idle_ready", 32'(bus.cpu_memory_ready), 32'd0);
      chk("rg_idle_en", 32'(mem_en), 32'd0);
    end
    a[0] = A0; a[2] = A2;
    v = 4'b0101;
    tick();
    chk("rg_first_cpu0", 32'(bus.cpu_memory_ready), 32'b0001);
    v = 4'b0100;
    tick();
    chk("rg_then_cpu2", 32'(bus.cpu_memory_ready), 32'b0100);
    v = '0;
    tick();
    tick();

    // Lone CPU 2 fetch straight after reset.
    do_reset();
    a[2] = 11'h05A;
    v = 4'b0100;
    tick();
    chk("solo_ready", 32'(bus.cpu_memory_ready), 32'b0100);
    chk("solo_mem_addr", 32'(mem_addr), 32'h05A);
    chk("solo_mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("solo_ready_low", 32'(bus.cpu_memory_ready), 32'd0);
    chk("solo_data", 32'(bus.cpu_memory_data), 32'(pat(32'h05A)));
    v = '0;
    tick();

    // Random requesters: every request granted once, within N+1 cycles.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      handle_grants();
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          age[i]  = 0;
          a[i]    = AW'($urandom_range(0, 2**AW - 1));
        end
      end
      v = pend;
    end
    for (int k = 0; k < 20 && pend != '0; k++) begin
      tick();
      handle_grants();
      v = pend;
    end
    chk("drain_pending", 32'(pend), 32'd0);
    v = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
